arb_requester: RTL
==================

Name: arb_requester

Overview:
- Requester-side client for the two-way grant arbiter; one instance sits in front of each arbiter request port (A or B).
- Accepts a burst job from local logic, raises req, waits for its grant bit, issues one beat per granted cycle, then releases.
- Tolerates preemption (grant removed mid-burst) and bounds the wait for a grant with a timeout.

Parameters:
- LEN_W, 4, width of the job length and beat counter.
- TIMEOUT, 8, max consecutive ungranted cycles in REQ before abort; 0 disables the timeout.
- TO_W, 4, width of the wait counter; must hold TIMEOUT.

Ports:
- clock  input  1  single rising-edge clock
- reset_n  input  1  reset, asynchronous, active-low
- job_valid  input  1  job offered by local logic
- job_len  input  LEN_W  number of beats in the job; 0 means no transfer
- job_ready  output  1  requester can accept a job (combinational: state==IDLE)
- req  output  1  request to arbiter (registered)
- grant  input  1  this requester's grant bit from the arbiter
- beat_valid  output  1  a beat is transferred this cycle (combinational: grant & req & remaining!=0)
- beat_cnt  output  LEN_W  beats completed in the current job (registered)
- done  output  1  one-cycle pulse when the job completes (registered)
- err  output  1  one-cycle pulse when the job aborts on timeout (registered)

Behaviour:
- Reset (reset_n low, async):
  - state=IDLE; req, done, err, beat_cnt, remaining and wait counter all 0.
  - job_ready=1, because it decodes state.
- FSM states: IDLE, REQ, XFER, REL.
- IDLE:
  - job_valid & job_ready latches remaining=job_len and clears beat_cnt.
  - If job_len!=0: go to REQ, req=1 from the next cycle.
  - If job_len==0: go to REL with no request; done pulses in REL.
  - grant seen in IDLE is ignored; no beat.
- REQ: req=1; wait counter is cleared on every entry to REQ.
  - grant=1 at the edge: beat taken, go to XFER (or to REL if it was the last beat).
  - Otherwise the wait counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: go to REL with err=1 in REL, req=0 and no done.
- XFER: req=1; each edge with grant=1 decrements remaining and increments beat_cnt.
  - grant=0 (preempted): go back to REQ; remaining and beat_cnt are kept and req stays high.
  - Last beat (remaining 1→0): go to REL.
- REL:
  - req=0 for exactly one cycle, so the arbiter sees the drop and returns to idle.
  - done=1 (or err=1 on timeout); next state IDLE.
  - beat_cnt holds its final value until the next job is accepted.
- Latency: req rises 1 cycle after job acceptance.
  - First beat is on the first cycle grant=1 while req=1.
  - req falls on the cycle after the last beat.
- Simultaneous events:
  - job_valid during REQ/XFER/REL is not accepted (job_ready=0); the offering side holds it.
  - Timeout and grant on the same edge: grant wins.
- Reset mid-burst: req drops immediately (async) and the job is discarded; done and err stay 0.
- beat_cnt does not wrap within a job, since job_len ≤ 2^LEN_W−1.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, release → req=0, done=0, err=0, beat_cnt=0, job_ready=1.
- Basic burst: job_len=3, grant raised 1 cycle after req and held → beat_valid high 3 cycles, beat_cnt=3, req low for 1 cycle with done=1 on that cycle, then job_ready=1.
- Preemption: job_len=4, grant high 2 cycles, low 3 cycles, high again → exactly 4 beats total; req stays 1 through the gap; beat_cnt=2 during the gap; done once at the end.
- Timeout: TIMEOUT=8, job_len=2, grant held 0 → req high 8 cycles, then req=0 with err=1 for 1 cycle; done=0, beat_cnt=0.
- Zero-length and spurious grant: job_len=0 → no req, done pulses 1 cycle after acceptance; grant=1 while IDLE → beat_valid=0.
- Reset mid-burst: assert reset_n=0 after 2 of 5 beats → req=0 immediately; after release, job_ready=1 and beat_cnt=0.

Source files
------------

// File: rtl/arb_requester.sv
// Requester-side client for the two-way grant arbiter.
// Accepts a burst job from local logic, raises req, issues one beat per
// granted cycle, and drops req for exactly one cycle when the job ends.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no job; job_ready=1; grant is ignored
//   REQ   | req=1, waiting for grant; wait counter bounds the wait
//   XFER  | req=1, granted; one beat per cycle while grant stays high
//   REL   | req=0 for one cycle; done (or err on timeout) pulses here
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             job_valid,
  input  logic [LEN_W-1:0] job_len,
  output logic             job_ready,
  output logic             req,
  input  logic             grant,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [TO_W-1:0]  wait_cnt;
  logic [TO_W-1:0]  wait_nxt;
  logic             timeout_hit;
  logic             last_beat;

  // Handshake decode and beat qualifier; the remaining!=0 term keeps a
  // stray grant from ever producing a beat outside a live job.
  assign job_ready   = (state == IDLE);
  assign beat_valid  = grant & req & (remaining != '0);
  assign last_beat   = (remaining == LEN_W'(1));
  assign wait_nxt    = wait_cnt + TO_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wait_nxt == TO_W'(TIMEOUT));

  // Sequencer: state, request line, counters and completion pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      req       <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      beat_cnt  <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (job_valid) begin
            remaining <= job_len;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            if (job_len != '0) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              // Empty job: complete without ever touching the arbiter.
              state <= REL;
              done  <= 1'b1;
            end
          end
        end
        REQ: begin
          // A grant on the timeout edge still wins.
          if (grant) begin
            remaining <= remaining - LEN_W'(1);
            beat_cnt  <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              state <= REL;
              req   <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= XFER;
            end
          end else if (timeout_hit) begin
            state <= REL;
            req   <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_nxt;
          end
        end
        XFER: begin
          if (grant) begin
            remaining <= remaining - LEN_W'(1);
            beat_cnt  <= beat_cnt + LEN_W'(1);
            if (last_beat) begin
              state <= REL;
              req   <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            // Preempted: keep progress and keep requesting, restart the wait.
            state    <= REQ;
            wait_cnt <= '0;
          end
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule
